// File: rtl/loba_pkg.sv
// Shared encodings and default widths for the loba accumulator block.
package loba_pkg;
    localparam int N     = 16;
    localparam int ACC_W = 40;
    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/loba_acc_if.sv
// Job/product/result handshake bundle between the loba accumulator and its neighbours.
interface loba_acc_if #(
    parameter int N     = loba_pkg::N,
    parameter int ACC_W = loba_pkg::ACC_W,
    parameter int LEN_W = loba_pkg::LEN_W
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             p_valid;
    logic [2*N-1:0]   p_data;
    logic             p_ready;
    logic             sum_valid;
    logic [ACC_W-1:0] sum;
    logic             sum_ready;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, p_valid, p_data, sum_ready,
        input  p_ready, sum_valid, sum, ovf, busy
    );

    modport slave (
        input  start, len, p_valid, p_data, sum_ready,
        output p_ready, sum_valid, sum, ovf, busy
    );
endinterface

// File: rtl/loba_sat_add.sv
// Unsigned saturating add: y = min(a + b, 2^ACC_W-1); sat flags the clamp.
module loba_sat_add #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] y,
    output logic             sat
);
    // One extra bit catches the carry-out; IN_W <= ACC_W is assumed by the caller.
    logic [ACC_W:0] full;

    assign full = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
    assign sat  = full[ACC_W];
    assign y    = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];
endmodule

// File: rtl/loba_acc.sv
// Job-based saturating accumulator for approximate-multiplier products.
// Outputs are the accumulator/flag registers or state decodes only.
module loba_acc #(
    parameter int N     = loba_pkg::N,
    parameter int ACC_W = loba_pkg::ACC_W,
    parameter int LEN_W = loba_pkg::LEN_W
) (
    input  logic         clk,
    input  logic         rst,
    loba_acc_if.slave    bus
);
    import loba_pkg::*;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_add;
    logic [LEN_W-1:0] cnt;
    logic             ovf_q, sat, clr, xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_n = (bus.len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                xfer = bus.p_valid;
                if (bus.p_valid && cnt == LEN_W'(1)) state_n = DONE;
            end
            DONE: begin
                if (bus.sum_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    loba_sat_add #(.IN_W(2*N), .ACC_W(ACC_W)) u_add (
        .a   (acc),
        .b   (bus.p_data),
        .y   (acc_add),
        .sat (sat)
    );

    // Once saturated, further adds stay at all ones, so ovf only needs to OR in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            cnt   <= bus.len;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            acc   <= acc_add;
            cnt   <= cnt - LEN_W'(1);
            ovf_q <= ovf_q | sat;
        end
    end

    assign bus.p_ready   = (state == ACC);
    assign bus.sum_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = acc;
    assign bus.ovf       = ovf_q;
endmodule
